// File: rtl/xadc_multichannel_packetizer_pkg.sv
// Shared types and constants for the multichannel XADC COBS packetizer.
package xadc_multichannel_packetizer_pkg;

    localparam logic [7:0] COBS_DELIMITER      = 8'h00;
    localparam int         COBS_MAX_RAW_LENGTH = 254;

    typedef enum logic [1:0] {
        ST_CAPTURE    = 2'd0,
        ST_EMIT_CODE  = 2'd1,
        ST_EMIT_DATA  = 2'd2,
        ST_EMIT_DELIM = 2'd3
    } packetizer_state_t;

    function automatic int bytes_per_sample(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/xadc_multichannel_packetizer_if.sv
// Sample-side and byte-side AXI-Stream signals of the packetizer.
interface xadc_multichannel_packetizer_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 16
);
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_tdata;
    logic [NUM_CHANNELS-1:0]              s_tvalid;
    logic [NUM_CHANNELS-1:0]              s_tready;
    logic [7:0]                           m_tdata;
    logic                                 m_tvalid;
    logic                                 m_tready;
    logic                                 m_tlast;

    modport master (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/xadc_multichannel_packetizer_cobs_next_zero.sv
// Priority encoder: index of the first zero byte at or after start_i,
// or RAW_LENGTH when the rest of the frame holds no zero.
module xadc_multichannel_packetizer_cobs_next_zero #(
    parameter int RAW_LENGTH = 4
) (
    input  logic [RAW_LENGTH-1:0] zero_flags_i,
    input  logic [7:0]            start_i,
    output logic [7:0]            z_o
);

    // Scan downwards so the lowest qualifying index wins.
    always_comb begin
        z_o = 8'(RAW_LENGTH);
        for (int i = RAW_LENGTH - 1; i >= 0; i--) begin
            z_o = (zero_flags_i[i] && (8'(i) >= start_i)) ? 8'(i) : z_o;
        end
    end

endmodule

// File: rtl/xadc_multichannel_packetizer.sv
// Collects one sample per channel, serialises them big-endian behind an
// optional sequence byte, and streams the frame COBS-encoded with a 0x00 delimiter.
module xadc_multichannel_packetizer
    import xadc_multichannel_packetizer_pkg::*;
#(
    parameter int NUM_CHANNELS     = 2,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int INCLUDE_SEQUENCE = 0
) (
    input  logic clk,
    input  logic reset_n,
    xadc_multichannel_packetizer_if.master bus
);

    localparam int BPS        = bytes_per_sample(SAMPLE_WIDTH);
    localparam int SEQ_LEN    = (INCLUDE_SEQUENCE != 0) ? 1 : 0;
    localparam int RAW_LENGTH = SEQ_LEN + NUM_CHANNELS * BPS;
    localparam int CH_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [7:0]      RAW_LEN_B = 8'(RAW_LENGTH);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CH_W-1:0] CH_ZERO   = {CH_W{1'b0}};

    if (RAW_LENGTH > COBS_MAX_RAW_LENGTH) begin : g_raw_length_check
        $error("raw frame longer than a single COBS block");
    end

    packetizer_state_t       state_q, state_d, code_state_s;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [7:0]              p_q, p_d, code_p_s;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              raw_q [RAW_LENGTH];
    logic [7:0]              raw_d [RAW_LENGTH];
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [NUM_CHANNELS-1:0] tready_q, tready_d;

    logic [SAMPLE_WIDTH-1:0] sample_s;
    logic [BPS*8-1:0]        sample_ext_s;
    logic [RAW_LENGTH-1:0]   zero_flags_s;
    logic [7:0]              p_sel_s, z_s, code_s, rd_byte_s;
    logic                    hs_s, load_s, last_hs_s;

    // s_tready is one-hot on ch in CAPTURE and zero elsewhere, so any set bit is the handshake.
    assign hs_s      = |(bus.s_tvalid & tready_q);
    assign last_hs_s = hs_s && (ch_q == LAST_CH);
    assign load_s    = !tvalid_q || bus.m_tready;

    // Select the channel being captured and zero-extend it to whole bytes.
    always_comb begin
        sample_s = {SAMPLE_WIDTH{1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sample_s = (ch_q == CH_W'(c)) ? bus.s_tdata[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] : sample_s;
        end
        sample_ext_s = (BPS*8)'(sample_s);
    end

    // Next raw-frame contents; the seq byte is latched with channel 0.
    always_comb begin
        raw_d    = raw_q;
        raw_d[0] = (SEQ_LEN == 1 && hs_s && ch_q == CH_ZERO) ? seq_q : raw_q[0];
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int j = 0; j < BPS; j++) begin
                raw_d[SEQ_LEN + c*BPS + j] = (hs_s && ch_q == CH_W'(c))
                    ? sample_ext_s[(BPS-1-j)*8 +: 8] : raw_q[SEQ_LEN + c*BPS + j];
            end
        end
    end

    // Zero flags follow raw_d so the first code byte can see the sample captured this cycle.
    always_comb begin
        rd_byte_s = 8'h00;
        for (int k = 0; k < RAW_LENGTH; k++) begin
            zero_flags_s[k] = (raw_d[k] == COBS_DELIMITER);
            rd_byte_s       = (p_q == 8'(k)) ? raw_q[k] : rd_byte_s;
        end
    end

    assign p_sel_s = (state_q == ST_CAPTURE) ? 8'h00 : p_q;
    assign code_s  = z_s - p_sel_s + 8'd1;

    xadc_multichannel_packetizer_cobs_next_zero #(
        .RAW_LENGTH (RAW_LENGTH)
    ) u_next_zero (
        .zero_flags_i (zero_flags_s),
        .start_i      (p_sel_s),
        .z_o          (z_s)
    );

    // Where to go after a code byte: a zero right here is consumed as code 0x01.
    always_comb begin
        if (z_s == p_sel_s && z_s != RAW_LEN_B) begin
            code_p_s     = p_sel_s + 8'd1;
            code_state_s = ST_EMIT_CODE;
        end else if (z_s == p_sel_s) begin
            code_p_s     = p_sel_s;
            code_state_s = ST_EMIT_DELIM;
        end else begin
            code_p_s     = p_sel_s;
            code_state_s = ST_EMIT_DATA;
        end
    end

    // Next-state and output-register logic; a new byte is loaded only when the slot is free.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        p_d      = p_q;
        seq_d    = seq_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        case (state_q)
            ST_CAPTURE: begin
                if (last_hs_s) begin
                    ch_d     = CH_ZERO;
                    tdata_d  = code_s;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    p_d      = code_p_s;
                    state_d  = code_state_s;
                end else if (hs_s) begin
                    ch_d = ch_q + CH_W'(1);
                end else begin
                    ch_d = ch_q;
                end
            end
            ST_EMIT_CODE: begin
                if (load_s) begin
                    tdata_d  = code_s;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    p_d      = code_p_s;
                    state_d  = code_state_s;
                end else begin
                    state_d = ST_EMIT_CODE;
                end
            end
            ST_EMIT_DATA: begin
                if (load_s) begin
                    tdata_d  = rd_byte_s;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    if (p_q + 8'd1 != z_s) begin
                        p_d = p_q + 8'd1;
                    end else if (z_s != RAW_LEN_B) begin
                        p_d     = z_s + 8'd1;
                        state_d = ST_EMIT_CODE;
                    end else begin
                        p_d     = z_s;
                        state_d = ST_EMIT_DELIM;
                    end
                end else begin
                    state_d = ST_EMIT_DATA;
                end
            end
            ST_EMIT_DELIM: begin
                if (tvalid_q && tlast_q) begin
                    if (bus.m_tready) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        seq_d    = seq_q + 8'd1;
                        ch_d     = CH_ZERO;
                        state_d  = ST_CAPTURE;
                    end else begin
                        state_d = ST_EMIT_DELIM;
                    end
                end else if (load_s) begin
                    tdata_d  = COBS_DELIMITER;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                end else begin
                    state_d = ST_EMIT_DELIM;
                end
            end
            default: begin
                state_d  = ST_CAPTURE;
                ch_d     = CH_ZERO;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
        tready_d = (state_d == ST_CAPTURE) ? (NUM_CHANNELS'(1'b1) << ch_d) : {NUM_CHANNELS{1'b0}};
    end

    // State, frame buffer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_CAPTURE;
            ch_q     <= CH_ZERO;
            p_q      <= 8'h00;
            seq_q    <= 8'h00;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tready_q <= NUM_CHANNELS'(1'b1);
            for (int k = 0; k < RAW_LENGTH; k++) begin
                raw_q[k] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            p_q      <= p_d;
            seq_q    <= seq_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tready_q <= tready_d;
            raw_q    <= raw_d;
        end
    end

    assign bus.s_tready = tready_q;
    assign bus.m_tdata  = tdata_q;
    assign bus.m_tvalid = tvalid_q;
    assign bus.m_tlast  = tlast_q;

endmodule

// File: tb/tb_xadc_multichannel_packetizer.sv
// Scoreboard bench: three packetizer configurations, expected COBS bytes queued
// at stimulus time and popped by a monitor on every accepted output byte.
module tb_xadc_multichannel_packetizer;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic stall_en = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   acc [3];
    logic       prev_stall [3];
    logic [8:0] prev_out   [3];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    always #5 clk = ~clk;

    xadc_multichannel_packetizer_if #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(16)) if0 ();
    xadc_multichannel_packetizer_if #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(16)) if1 ();
    xadc_multichannel_packetizer_if #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(12)) if2 ();

    xadc_multichannel_packetizer #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(16), .INCLUDE_SEQUENCE(0))
        u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    xadc_multichannel_packetizer #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(16), .INCLUDE_SEQUENCE(1))
        u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    xadc_multichannel_packetizer #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(12), .INCLUDE_SEQUENCE(0))
        u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue n bytes given MSB-first in b; the last one carries tlast.
    task automatic push(input int id, input int n, input logic [95:0] b);
        logic [8:0] e;
        for (int k = 0; k < n; k++) begin
            e = {(k == n - 1), b[(n-1-k)*8 +: 8]};
            case (id)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic mon(input int id, input logic v, input logic r, input logic [7:0] d,
                       input logic l, input logic rdy);
        logic [8:0] e;
        int sz;
        if (!reset_n) begin
            prev_stall[id] = 1'b0;
        end else begin
            if (prev_stall[id])
                chk($sformatf("dut%0d_hold_under_stall", id), {22'd0, v, l, d}, {22'd0, 1'b1, prev_out[id]});
            if (v)
                chk($sformatf("dut%0d_s_tready_idle_while_emitting", id), {31'd0, rdy}, 32'd0);
            if (v && r) begin
                case (id)
                    0:       sz = q0.size();
                    1:       sz = q1.size();
                    default: sz = q2.size();
                endcase
                total++;
                if (sz == 0) begin
                    bad++;
                    $display("FAIL dut%0d_unexpected_byte: got %0h, expected none", id, {l, d});
                end else begin
                    case (id)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    if ({l, d} !== e) begin
                        bad++;
                        $display("FAIL dut%0d_byte: got last=%0b data=%02h, expected last=%0b data=%02h",
                                 id, l, d, e[8], e[7:0]);
                    end
                end
                acc[id]++;
            end
            prev_stall[id] = v && !r;
            prev_out[id]   = {l, d};
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0;
            prev_stall[i] = 1'b0;
            prev_out[i] = 9'd0;
        end
        forever begin
            @(negedge clk);
            mon(0, if0.m_tvalid, if0.m_tready, if0.m_tdata, if0.m_tlast, |if0.s_tready);
            mon(1, if1.m_tvalid, if1.m_tready, if1.m_tdata, if1.m_tlast, |if1.s_tready);
            mon(2, if2.m_tvalid, if2.m_tready, if2.m_tdata, if2.m_tlast, |if2.s_tready);
        end
    end

    initial begin
        if0.m_tready = 1'b1;
        if1.m_tready = 1'b1;
        if2.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if0.m_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic wait_rdy(input int id, input int ch);
        logic [3:0] r;
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            case (id)
                0:       r = 4'(if0.s_tready);
                1:       r = 4'(if1.s_tready);
                default: r = if2.s_tready;
            endcase
            got = r[ch[1:0]];
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL dut%0d_ready_timeout: got no s_tready on ch%0d, expected it within 200 cycles", id, ch);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        if0.s_tdata = {b, a};
        if0.s_tvalid = 2'b01; wait_rdy(0, 0);
        if0.s_tvalid = 2'b10; wait_rdy(0, 1);
        if0.s_tvalid = 2'b00;
        chk("dut0_first_code_latency", {31'd0, if0.m_tvalid}, 32'd1);
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        if1.s_tdata = {b, a};
        if1.s_tvalid = 2'b01; wait_rdy(1, 0);
        if1.s_tvalid = 2'b10; wait_rdy(1, 1);
        if1.s_tvalid = 2'b00;
        chk("dut1_first_code_latency", {31'd0, if1.m_tvalid}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
        chk("drain_empty", q0.size() + q1.size() + q2.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected it within 300000 time units");
        $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
    end

    initial begin
        int a;
        if0.s_tdata = '0; if0.s_tvalid = '0;
        if1.s_tdata = '0; if1.s_tvalid = '0;
        if2.s_tdata = '0; if2.s_tvalid = '0;
        repeat (3) @(negedge clk);
        chk("reset_m_tvalid", {31'd0, if0.m_tvalid}, 32'd0);
        chk("reset_m_tlast",  {31'd0, if0.m_tlast},  32'd0);
        chk("reset_m_tdata",  {24'd0, if0.m_tdata},  32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_s_tready_dut0", {30'd0, if0.s_tready}, 32'h1);
        chk("reset_s_tready_dut2", {28'd0, if2.s_tready}, 32'h1);

        push(0, 6, 96'h01_02_FF_02_7F_00);
        send0(16'h00FF, 16'h007F);
        drain();

        push(0, 6, 96'h05_AB_AB_AB_AB_00);
        send0(16'hABAB, 16'hABAB);
        drain();

        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) push(0, 6, 96'h05_AB_AB_AB_AB_00);
        for (int k = 0; k < 3; k++) send0(16'hABAB, 16'hABAB);
        drain();
        stall_en = 1'b0;

        // Channel 1 offered first must wait for channel 0.
        push(0, 6, 96'h05_03_04_01_02_00);
        @(posedge clk); #1;
        if0.s_tdata  = {16'h0102, 16'h0304};
        if0.s_tvalid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ch1_held_off", {31'd0, if0.s_tready[1]}, 32'd0);
        end
        @(posedge clk); #1;
        if0.s_tvalid = 2'b11; wait_rdy(0, 0);
        if0.s_tvalid = 2'b10; wait_rdy(0, 1);
        if0.s_tvalid = 2'b00;
        drain();

        for (int k = 0; k < 3; k++) begin
            if (k == 0) push(1, 7, 96'h01_05_12_34_56_78_00);
            else        push(1, 7, {40'd0, 8'h06, 8'(k), 32'h12345678, 8'h00});
        end
        for (int k = 0; k < 3; k++) send1(16'h1234, 16'h5678);
        drain();

        push(2, 10, 96'h01_01_01_01_01_01_01_01_01_00);
        @(posedge clk); #1;
        if2.s_tdata = 48'h0;
        for (int c = 0; c < 4; c++) begin
            if2.s_tvalid = 4'(1 << c);
            wait_rdy(2, c);
        end
        if2.s_tvalid = 4'b0000;
        chk("dut2_first_code_latency", {31'd0, if2.m_tvalid}, 32'd1);
        drain();

        // Reset in the middle of a packet discards it and restarts the sequence.
        push(1, 7, 96'h06_03_12_34_56_78_00);
        a = acc[1];
        send1(16'h1234, 16'h5678);
        for (int i = 0; i < 100 && acc[1] < a + 2; i++) @(negedge clk);
        chk("dut1_bytes_before_reset", {31'd0, acc[1] >= a + 2}, 32'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("reset_async_m_tvalid", {31'd0, if1.m_tvalid}, 32'd0);
        q0.delete(); q1.delete(); q2.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_s_tready_dut1", {30'd0, if1.s_tready}, 32'h1);
        push(1, 7, 96'h01_05_12_34_56_78_00);
        send1(16'h1234, 16'h5678);
        drain();

        repeat (4) @(negedge clk);
        chk("final_queues_empty", q0.size() + q1.size() + q2.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xadc_multichannel_packetizer.md
# xadc_multichannel_packetizer

Parametrised successor to the two-channel XADC packetizer. It collects one sample from each of NUM_CHANNELS AXI-Stream sample channels, serialises them big-endian into a raw frame with an optional sequence header, and COBS-encodes that frame onto an 8-bit AXI-Stream with a 0x00 delimiter. It sits between xadc_drp_axis_adapter (or any sample source) and the USB/UART byte transport.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of sample input channels (≥1)
- SAMPLE_WIDTH, 16, bits per sample (1..32); zero-extended to BYTES_PER_SAMPLE = ceil(SAMPLE_WIDTH/8) bytes
- INCLUDE_SEQUENCE, 0, 1 prepends an 8-bit packet sequence byte to the raw frame

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- s_tdata  in  NUM_CHANNELS×SAMPLE_WIDTH  per-channel sample data
- s_tvalid  in  NUM_CHANNELS  per-channel valid
- s_tready  out  NUM_CHANNELS  per-channel ready
- m_tdata  out  8  encoded byte
- m_tvalid  out  1  encoded byte valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  high on the 0x00 delimiter byte

## Operation
- Raw frame: [seq if INCLUDE_SEQUENCE] then channel 0..N-1, each MSB byte first. RAW_LENGTH = INCLUDE_SEQUENCE + NUM_CHANNELS×BYTES_PER_SAMPLE. Elaboration error if RAW_LENGTH > 254, so no 0xFF code blocks exist.
- States: CAPTURE → EMIT_CODE ↔ EMIT_DATA → EMIT_DELIM → CAPTURE.
- CAPTURE: channel index ch starts at 0; s_tready[ch]=1, all other s_tready 0. Sample stored on s_tvalid[ch]&&s_tready[ch]; ch increments. After channel N-1 is accepted, p := 0, go to EMIT_CODE.
- EMIT_CODE at position p: z = index of the first zero byte at or after p, else RAW_LENGTH. Emit code = z−p+1. If z=p (code 1), the zero is consumed: p := p+1 and stay in EMIT_CODE; otherwise go to EMIT_DATA.
- EMIT_DATA: emit raw[p], p++ until p = z. Then, if z < RAW_LENGTH, skip the zero (p := z+1) and go to EMIT_CODE, even if p now equals RAW_LENGTH (a trailing zero produces a final code 0x01). If z = RAW_LENGTH, go to EMIT_DELIM.
- EMIT_DELIM: emit 0x00 with m_tlast=1. On accept, seq increments mod 256, ch := 0, go to CAPTURE.
- Encoded length is always RAW_LENGTH+2 bytes.

## Timing
- Reset (async assert, sync release): state CAPTURE, ch=0, seq=0, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready = one-hot bit 0 from the first cycle after release. A partial packet at reset is discarded.
- Outputs registered. m_tdata/m_tlast held stable while m_tvalid && !m_tready; m_tvalid never drops without a handshake.
- Capture: one sample per cycle at best, N cycles minimum. The first code byte has m_tvalid in the cycle after the last sample handshake.
- Emit: one byte per cycle while m_tready=1. All s_tready are 0 from the last capture until the delimiter is accepted; there is no overlap. Minimum period is N + RAW_LENGTH + 2 cycles.
- Upstream valid on a non-selected channel is held off. It is never dropped and never reordered.

## Structure
- Add to xadc_packet_package: COBS_DELIMITER (8'h00), COBS_MAX_RAW_LENGTH (254), function bytes_per_sample(width), and the packetizer_state_t enum.
- One sub-module, cobs_next_zero: a combinational priority encoder over a RAW_LENGTH zero-flag vector from start index p. It returns z, and RAW_LENGTH when there is no zero.
- The raw frame buffer is a register array of RAW_LENGTH bytes. Raw bytes are regenerated from the captured samples; no separate encode buffer.

## Test plan
- Defaults, V=0x00FF then C=0x007F → 01 02 FF 02 7F 00, tlast only on the last byte.
- INCLUDE_SEQUENCE=1, three packets of 0x1234/0x5678 → seq bytes 00, 01, 02. First packet 01 05 12 34 56 78 00. Following packets 06 01 12 34 56 78 00 and 06 02 12 34 56 78 00.
- NUM_CHANNELS=4, SAMPLE_WIDTH=12, all samples 0x000 (raw 8×00) → 01×9 then 00.
- Random m_tready toggling at 50% with all-0xAB samples → byte stream identical to the ready-always run; tdata stable under stall.
- Channel 1 valid before channel 0 → s_tready[1] stays low until channel 0 is accepted; order preserved.
- reset_n asserted during EMIT_DATA → m_tvalid=0 immediately, seq=0. The next packet is complete and correct.
